seg7_scan_display: RTL and testbench

- Downstream stage of the digital clock's time counter. Consumes its 24-bit time word: hours, minutes and seconds, one binary byte each.
- Converts each byte to two BCD digits and drives a 6-digit common-anode seven-segment display through time-multiplexed scanning.
- Includes anti-ghost blanking and a seconds-blink colon (DP).
- All outputs are registered and the block runs in the 50 MHz system clock domain.

---
 rtl/seg7_scan_display.sv | 105 ++++++++++
 tb/tb_seg7_scan_display.sv | 128 ++++++++++++
 2 files changed

// File: rtl/seg7_scan_display.sv
// Six-digit common-anode seven-segment scanner for the HH:MM:SS time word.
// The time word is captured once per frame, and each digit slot begins with a short blanking window.
module seg7_scan_display #(
    parameter int unsigned SCAN_DIV  = 50_000,
    parameter int unsigned BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] data_in,
    output logic [5:0]  sel,
    output logic [7:0]  seg
);

    localparam int unsigned    CW        = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]  BLANK_END = CW'(BLANK_CYC);
    localparam logic [3:0]     DASH      = 4'd10;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [23:0]   snap_q, snap_d;
    logic [5:0]    sel_q, sel_d;
    logic [7:0]    seg_q, seg_d;

    logic [7:0]    byte_val;
    logic [3:0]    digit;
    logic          dp_n;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] code;
        case (d)
            4'd0:    code = 7'h40;
            4'd1:    code = 7'h79;
            4'd2:    code = 7'h24;
            4'd3:    code = 7'h30;
            4'd4:    code = 7'h19;
            4'd5:    code = 7'h12;
            4'd6:    code = 7'h02;
            4'd7:    code = 7'h78;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h10;
            default: code = 7'h3F;
        endcase
        return code;
    endfunction

    always_comb begin
        cnt_d  = cnt_q + CW'(1);
        idx_d  = idx_q;
        snap_d = snap_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
            // Frame boundary: a whole frame always shows one captured time value.
            if (idx_q == 3'd5) begin
                snap_d = data_in;
            end
        end
    end

    always_comb begin
        case (idx_q[2:1])
            2'd0:    byte_val = snap_q[7:0];
            2'd1:    byte_val = snap_q[15:8];
            default: byte_val = snap_q[23:16];
        endcase

        if (byte_val > 8'd99) begin
            digit = DASH;
        end else if (idx_q[0]) begin
            digit = 4'(byte_val / 8'd10);
        end else begin
            digit = 4'(byte_val % 8'd10);
        end

        dp_n = !(((idx_q == 3'd2) || (idx_q == 3'd4)) && !snap_q[0]);

        seg_d = {dp_n, seg_code(digit)};
        if (cnt_q < BLANK_END) begin
            sel_d = '1;
        end else begin
            sel_d = ~(6'd1 << idx_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            snap_q <= '0;
            sel_q  <= '1;
            seg_q  <= '1;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            sel_q  <= sel_d;
            seg_q  <= seg_d;
        end
    end

    assign sel = sel_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with SCAN_DIV=8 and BLANK_CYC=2.
// The expected segment bytes below are derived by hand from the digit map and the segment table.
module tb_seg7_scan_display;

    logic        clk;
    logic        rst;
    logic [23:0] data_in;
    logic [5:0]  sel;
    logic [7:0]  seg;

    int unsigned vectors = 0;
    int unsigned errors  = 0;
    logic        mon_en  = 1'b0;

    seg7_scan_display #(
        .SCAN_DIV  (8),
        .BLANK_CYC (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .sel     (sel),
        .seg     (seg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs n cycles of one digit slot: two blank cycles, then a single select low.
    task automatic check_slot(input int unsigned idx, input logic [7:0] exp_seg, input int unsigned n);
        logic [5:0] on_sel;
        on_sel = ~(6'd1 << idx);
        for (int unsigned c = 0; c < n; c++) begin
            tick();
            chk($sformatf("sel idx%0d cyc%0d", idx, c), {2'b00, sel},
                (c < 2) ? 8'h3F : {2'b00, on_sel});
            chk($sformatf("seg idx%0d cyc%0d", idx, c), seg, exp_seg);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            vectors++;
            assert ($countones(~sel) <= 1) else begin
                errors++;
                $error("FAIL sel_exclusive: observed %b expected at most one low bit", sel);
            end
        end
    end

    initial begin
        rst     = 1'b1;
        data_in = 24'h17_3B_3B;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset sel", {2'b00, sel}, 8'h3F);
            chk("reset seg", seg, 8'hFF);
        end
        mon_en = 1'b1;

        // Release; new data must not appear until the first frame boundary.
        rst     = 1'b0;
        data_in = 24'h0C_22_05;
        check_slot(0, 8'hC0, 8);
        check_slot(1, 8'hC0, 8);
        check_slot(2, 8'h40, 8);
        check_slot(3, 8'hC0, 8);
        check_slot(4, 8'h40, 8);
        check_slot(5, 8'hC0, 8);

        // 12:34:05, odd second: no colon. Mid-frame data change is held off.
        check_slot(0, 8'h92, 8);
        check_slot(1, 8'hC0, 8);
        check_slot(2, 8'h99, 8);
        data_in = 24'h17_3B_3A;
        check_slot(3, 8'hB0, 8);
        check_slot(4, 8'hA4, 8);
        check_slot(5, 8'hF9, 8);

        // 23:59:58, even second: colon on idx2 and idx4.
        check_slot(0, 8'h80, 8);
        check_slot(1, 8'h92, 8);
        check_slot(2, 8'h10, 8);
        data_in = {8'd1, 8'd120, 8'd1};
        check_slot(3, 8'h92, 8);
        check_slot(4, 8'h30, 8);
        check_slot(5, 8'hA4, 8);

        // 01:120:01 -> minutes out of range show dashes.
        check_slot(0, 8'hF9, 8);
        check_slot(1, 8'hC0, 8);
        check_slot(2, 8'hBF, 8);
        check_slot(3, 8'hBF, 3);

        rst = 1'b1;
        tick();
        chk("midreset sel", {2'b00, sel}, 8'h3F);
        chk("midreset seg", seg, 8'hFF);
        rst = 1'b0;

        check_slot(0, 8'hC0, 8);
        check_slot(1, 8'hC0, 8);
        check_slot(2, 8'h40, 8);
        check_slot(3, 8'hC0, 8);
        check_slot(4, 8'h40, 8);
        check_slot(5, 8'hC0, 8);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
